// File: rtl/mac_sequencer_pkg.sv
// Shared types and constants for the MAC sequencer and its flag pipeline.
package mac_sequencer_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Per-term sideband carried alongside the datapath
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } term_flags_t;

    // Memory read (1) + MAC product register (1) + MAC accumulator (1)
    localparam int PIPE_DEPTH  = 3;
    // After the final issue, wait until that term leaves the last stage
    localparam int DRAIN_LEN   = PIPE_DEPTH;
    localparam int DRAIN_CNT_W = $clog2(DRAIN_LEN);

endpackage

// File: rtl/mac_seq_flag_pipe.sv
// Shift register that delays each issued term's flags so they line up with
// the operand memory and MAC pipeline stages. Index 0 is stage s1.
module mac_seq_flag_pipe
    import mac_sequencer_pkg::*;
(
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  term_flags_t                   flags_i,
    output term_flags_t [PIPE_DEPTH-1:0]  stages_o
);

    term_flags_t [PIPE_DEPTH-1:0] stage_q;

    // Shift the flags one stage per cycle; reset empties every stage
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[PIPE_DEPTH-2:0], flags_i};
        end
    end

    assign stages_o = stage_q;

endmodule

// File: rtl/mac_sequencer.sv
// Sequences a pipelined MAC through count dot products of length len,
// issuing operand addresses and the MAC strobes aligned to pipeline latency.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [LEN_WIDTH-1:0]  b_addr,
    output logic                  rd_en,
    output logic                  p_valid,
    output logic                  input_valid,
    output logic                  accumulate_internal,
    output logic                  out_valid
);

    localparam logic [LEN_WIDTH-1:0]   LEN_ONE    = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = DRAIN_CNT_W'(1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_LEN - 1);

    seq_state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [CNT_WIDTH-1:0]      count_q, count_d;
    logic [LEN_WIDTH-1:0]      k_q, k_d;
    logic [CNT_WIDTH-1:0]      v_q, v_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DRAIN_CNT_W-1:0]    drain_q, drain_d;
    logic                      zero_done_q, zero_done_d;

    logic                      cfg_ok;
    logic                      k_last;
    logic                      v_last;
    logic                      drain_last;
    term_flags_t               flags_in;
    term_flags_t [PIPE_DEPTH-1:0] stages;
    logic                      unused_flags;

    assign cfg_ok     = (cfg_len != '0) && (cfg_count != '0);
    assign k_last     = (k_q == len_q - LEN_ONE);
    assign v_last     = (v_q == count_q - CNT_ONE);
    assign drain_last = (drain_q == DRAIN_LAST);

    // Next-state logic: command acceptance, term counters and drain timer
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        k_d         = k_q;
        v_d         = v_q;
        addr_d      = addr_q;
        drain_d     = drain_q;
        zero_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        len_d   = cfg_len;
                        count_d = cfg_count;
                        k_d     = '0;
                        v_d     = '0;
                        addr_d  = '0;
                        drain_d = '0;
                        state_d = RUN;
                    end else begin
                        // Empty batch: acknowledge without touching the datapath
                        zero_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                addr_d = addr_q + ADDR_ONE;
                if (k_last) begin
                    k_d = '0;
                    v_d = v_q + CNT_ONE;
                    if (v_last) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end else begin
                    k_d = k_q + LEN_ONE;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + DRAIN_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q     <= IDLE;
            len_q       <= '0;
            count_q     <= '0;
            k_q         <= '0;
            v_q         <= '0;
            addr_q      <= '0;
            drain_q     <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            k_q         <= k_d;
            v_q         <= v_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            zero_done_q <= zero_done_d;
        end
    end

    // Tag the term being issued this cycle
    always_comb begin
        flags_in = '0;
        if (state_q == RUN) begin
            flags_in.valid = 1'b1;
            flags_in.first = (k_q == '0);
            flags_in.last  = k_last;
        end
    end

    mac_seq_flag_pipe u_flag_pipe (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .flags_i   (flags_in),
        .stages_o  (stages)
    );

    // Flag bits that no stage decode needs
    assign unused_flags = ^{stages[0].first, stages[0].last, stages[2].first};

    assign busy                = (state_q != IDLE);
    assign done                = (state_q == DRAIN && drain_last) || zero_done_q;
    assign rd_en               = (state_q == RUN);
    assign a_addr              = rd_en ? addr_q : '0;
    assign b_addr              = rd_en ? k_q : '0;
    assign p_valid             = stages[0].valid;
    assign input_valid         = stages[1].valid;
    // First term of a row restarts the sum instead of adding to the previous row
    assign accumulate_internal = stages[1].valid & ~stages[1].first;
    assign out_valid           = stages[2].valid & stages[2].last;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer with a behavioural memory + MAC model.
module tb_mac_sequencer;

    localparam int LW = 8;
    localparam int CW = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          start;
    logic [LW-1:0] cfg_len;
    logic [CW-1:0] cfg_count;
    logic          busy, done, rd_en, p_valid, input_valid, accumulate_internal, out_valid;
    logic [AW-1:0] a_addr;
    logic [LW-1:0] b_addr;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always #5 clk = ~clk;

    mac_sequencer #(.LEN_WIDTH(LW), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk                 (clk),
        .arst_n_in           (arst_n_in),
        .start               (start),
        .cfg_len             (cfg_len),
        .cfg_count           (cfg_count),
        .busy                (busy),
        .done                (done),
        .a_addr              (a_addr),
        .b_addr              (b_addr),
        .rd_en               (rd_en),
        .p_valid             (p_valid),
        .input_valid         (input_valid),
        .accumulate_internal (accumulate_internal),
        .out_valid           (out_valid)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural environment: A holds 2 everywhere, b[k] = k+1, 2-stage MAC
    int a_dat_m = 0, b_dat_m = 0, prod_m = 0, acc_m = 0;
    always @(posedge clk) begin
        if (arst_n_in === 1'b1) begin
            if (rd_en === 1'b1) begin
                a_dat_m <= 2;
                b_dat_m <= int'(b_addr) + 1;
            end
            if (p_valid === 1'b1) prod_m <= a_dat_m * b_dat_m;
            if (input_valid === 1'b1) acc_m <= (accumulate_internal === 1'b1) ? acc_m + prod_m : prod_m;
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, ".busy"}, busy, 1'b0);
        check_bit({tag, ".done"}, done, 1'b0);
        check_bit({tag, ".rd_en"}, rd_en, 1'b0);
        check_bit({tag, ".p_valid"}, p_valid, 1'b0);
        check_bit({tag, ".input_valid"}, input_valid, 1'b0);
        check_bit({tag, ".acc_int"}, accumulate_internal, 1'b0);
        check_bit({tag, ".out_valid"}, out_valid, 1'b0);
        check_val({tag, ".a_addr"}, 32'(a_addr), 32'd0);
        check_val({tag, ".b_addr"}, 32'(b_addr), 32'd0);
    endtask

    // Scoreboard of expected results: {cycle of out_valid, accumulator value}
    typedef struct {
        int due;
        int value;
    } sb_t;
    sb_t sb_q[$];

    always @(negedge clk) begin
        sb_t e;
        if (arst_n_in === 1'b1 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_bit("out_valid_unexpected", out_valid, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check_val("out_valid_cycle", cyc, e.due);
                check_val("result", acc_m, e.value);
                $display("[TB] result at cycle %0d: %0d (expected %0d at cycle %0d)", cyc, acc_m, e.value, e.due);
            end
        end
    end

    // Issue one command from a negedge and check every cycle from T0 to T0+len*cnt+3
    task automatic run_op(input int len, input int cnt, input bit hold, input int result);
        int cl;
        int t0;
        cl        = len * cnt;
        cfg_len   = LW'(len);
        cfg_count = CW'(cnt);
        start     = 1'b1;
        t0        = cyc + 1;
        for (int v = 0; v < cnt; v++) sb_q.push_back('{t0 + (v + 1) * len + 2, result});
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int i = 0; i <= cl + 3; i++) begin
            if (i > 0) @(negedge clk);
            check_bit("busy", busy, i <= cl + 2);
            check_bit("done", done, i == cl + 2);
            check_bit("rd_en", rd_en, i < cl);
            check_bit("p_valid", p_valid, i >= 1 && i <= cl);
            check_bit("input_valid", input_valid, i >= 2 && i <= cl + 1);
            check_bit("acc_int", accumulate_internal,
                      (i >= 2 && i <= cl + 1) && ((i - 2) % len != 0));
            check_bit("out_valid", out_valid,
                      (i >= len + 2 && i <= cl + 2) && ((i - 2) % len == 0));
            if (i < cl) begin
                check_val("a_addr", 32'(a_addr), i);
                check_val("b_addr", 32'(b_addr), i % len);
            end
        end
        check_val("sb_drained", sb_q.size(), 0);
        $display("[TB] op len=%0d count=%0d hold=%0b finished at cycle %0d", len, cnt, hold, cyc);
    endtask

    typedef struct {
        int len;
        int cnt;
        bit hold;
        int result;
    } vec_t;
    vec_t vecs[7];

    typedef struct {
        int len;
        int cnt;
    } zcfg_t;
    zcfg_t zvecs[2];

    initial begin
        // result = sum over k of 2*(k+1) = len*(len+1)
        vecs[0] = '{3,   2, 1'b0, 12};
        vecs[1] = '{1,   4, 1'b0, 2};
        vecs[2] = '{2,   2, 1'b1, 6};   // start held high into the next entry
        vecs[3] = '{2,   2, 1'b0, 6};
        vecs[4] = '{4,   3, 1'b0, 20};
        vecs[5] = '{5,   1, 1'b0, 30};
        vecs[6] = '{255, 1, 1'b0, 65280};
        zvecs[0] = '{0, 5};
        zvecs[1] = '{3, 0};

        arst_n_in = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        cfg_count = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        arst_n_in = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");

        // Empty commands: done pulse only
        for (int z = 0; z < 2; z++) begin
            cfg_len   = LW'(zvecs[z].len);
            cfg_count = CW'(zvecs[z].cnt);
            start     = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check_bit("zero.done", done, 1'b1);
            check_bit("zero.busy", busy, 1'b0);
            check_bit("zero.rd_en", rd_en, 1'b0);
            check_bit("zero.p_valid", p_valid, 1'b0);
            check_bit("zero.input_valid", input_valid, 1'b0);
            @(negedge clk);
            check_bit("zero.done_end", done, 1'b0);
            check_bit("zero.busy_end", busy, 1'b0);
            check_bit("zero.input_valid_end", input_valid, 1'b0);
            $display("[TB] empty command len=%0d count=%0d checked at cycle %0d", zvecs[z].len, zvecs[z].cnt, cyc);
        end

        // Reset in the middle of a run, then restart right after release
        cfg_len   = LW'(4);
        cfg_count = CW'(3);
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_bit("mid_run.rd_en_before_reset", rd_en, 1'b1);
        arst_n_in = 1'b0;
        #1;
        check_all_zero("mid_run_reset");
        sb_q.delete();
        @(negedge clk);
        check_all_zero("mid_run_reset_held");
        arst_n_in = 1'b1;
        #1;
        check_all_zero("after_release");
        $display("[TB] mid-run reset checked at cycle %0d", cyc);

        for (int n = 0; n < 7; n++) begin
            run_op(vecs[n].len, vecs[n].cnt, vecs[n].hold, vecs[n].result);
        end

        repeat (3) @(negedge clk);
        check_all_zero("final_idle");
        check_val("sb_final", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Controller that sequences one pipelined `mac` datapath through a batch of dot products, e.g. a matrix-vector product A·b.
- Accepts a start command with a vector length and a row count, then issues operand read addresses every cycle.
- Drives the MAC's `p_valid`, `input_valid` and `accumulate_internal` strobes, aligned to the operand-memory and MAC pipeline latencies.
- Flags each completed accumulator result with `out_valid`.
- Sits between the top-level control FSM and the operand SRAMs and `mac` instance.

## Interface
Parameters:
- `LEN_WIDTH`, 8: width of `cfg_len`; maximum vector length 2^LEN_WIDTH-1.
- `CNT_WIDTH`, 8: width of `cfg_count`; maximum row count 2^CNT_WIDTH-1.
- `ADDR_WIDTH`, 16: width of `a_addr`; the integrator guarantees that count·len-1 fits in this width.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `arst_n_in`, in, 1: asynchronous active-low reset.
- `start`, in, 1: command strobe; sampled only in IDLE.
- `cfg_len`, in, LEN_WIDTH: terms per dot product; latched when `start` is accepted.
- `cfg_count`, in, CNT_WIDTH: number of dot products; latched when `start` is accepted.
- `busy`, out, 1: high from the cycle after `start` is accepted until the cycle after `done`.
- `done`, out, 1: one-cycle completion pulse.
- `a_addr`, out, ADDR_WIDTH: A-memory read address.
- `b_addr`, out, LEN_WIDTH: b-memory read address.
- `rd_en`, out, 1: read enable for both memories.
- `p_valid`, out, 1: to the MAC product register.
- `input_valid`, out, 1: to the MAC accumulator.
- `accumulate_internal`, out, 1: to the MAC; 0 = restart the sum, 1 = accumulate.
- `out_valid`, out, 1: high for one cycle when the MAC `out` holds a final dot-product result.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - If `start`=1 and both cfg values are non-zero: latch config, clear counters, go to RUN.
  - If `start`=1 with `cfg_len`=0 or `cfg_count`=0: pulse `done` the next cycle. No `rd_en` or MAC strobes, no `busy`.
- RUN:
  - Every cycle: `rd_en`=1 and one term issued.
  - Counter `k` (0..len-1) drives `b_addr`. Counter `v` counts rows.
  - `a_addr` is a linear counter 0..count·len-1 (A stored row-major).
  - When `k` wraps: `k` returns to 0 and `v` increments.
  - After the term (v=count-1, k=len-1) is issued, go to DRAIN.
- DRAIN: 3 cycles with `rd_en`=0 to flush the pipeline, then IDLE.
  - `done` pulses in the last DRAIN cycle, coincident with the final `out_valid`.
- Flag pipeline: each issued term carries `first` (k=0) and `last` (k=len-1) through three stages, s1, s2, s3.
  - s1: `p_valid` = s1.valid (memory data present at the MAC `a`/`b` inputs).
  - s2: `input_valid` = s2.valid; `accumulate_internal` = s2.valid & ~s2.first.
  - s3: `out_valid` = s3.valid & s3.last.
- `start` while busy is ignored. No abort; only `arst_n_in` stops an operation.
- Reset, including mid-operation: state IDLE, counters 0, all flag stages invalid. Every output is 0 while reset is asserted and on the first cycle after release.
- `cfg_len`=1: every term is both first and last. `accumulate_internal` stays 0 and `out_valid` fires every cycle from cycle 3 after the first issue until done.

## Timing
- Memories have 1-cycle read latency; the MAC has a 2-register pipeline.
- Term issued in cycle c gives:
  - `p_valid` in cycle c+1.
  - `input_valid` in cycle c+2.
  - Accumulator result is valid, and `out_valid` marks it when that term is the last of its row, in cycle c+3.
- Let T0 be the first RUN cycle, the cycle after `start` is sampled:
  - `out_valid` for row v is asserted in cycle T0+(v+1)·len+2.
  - `done` is asserted in cycle T0+count·len+2.
  - `busy` is 1 from T0 through T0+count·len+2 and deasserts one cycle later.
- Back-to-back rows have no bubble. Row v+1's first term enters the accumulator (with `accumulate_internal`=0) in the cycle right after row v's result is flagged. The flagged result must be captured in that `out_valid` cycle.

## Structure
- Package `mac_sequencer_pkg`:
  - `seq_state_t` enum: IDLE, RUN, DRAIN.
  - `term_flags_t` struct: valid, first, last.
  - Constant `PIPE_DEPTH`=3, and the DRAIN length derived from it.
- Sub-module `mac_seq_flag_pipe`: a PIPE_DEPTH-stage shift register of `term_flags_t`, asynchronously reset to all-invalid.
- Top level holds the FSM, the k/v/address counters and the output decode.

## Test plan
- Reset mid-RUN (len=4, count=3, assert `arst_n_in` at T0+5): all outputs 0 immediately. A new `start` is accepted on the first cycle after release.
- len=3, count=2:
  - `a_addr` 0..5 on T0..T0+5; `b_addr` 0,1,2,0,1,2.
  - `accumulate_internal` 0,1,1,0,1,1 on T0+2..T0+7.
  - `out_valid` at T0+5 and T0+8; `done` at T0+8.
  - With a=2 for all terms and b=k+1, captured results are 12, 12.
- len=1, count=4:
  - `accumulate_internal` never 1.
  - `out_valid` at T0+3..T0+6; `done` at T0+6.
- `cfg_len`=0 with `start`: `done` pulse next cycle; `busy`, `rd_en`, `p_valid`, `input_valid` stay 0.
- `start` held high through an operation (len=2, count=2):
  - Exactly one operation runs.
  - A second operation starts only on the IDLE cycle after `busy` falls.
